snn_layer: RTL and testbench

Parametrised leaky integrate-and-fire excitatory layer. Successor to the fixed 10-input, 2-neuron network. Each accepted timestep carries an input spike vector. The layer accumulates per-synapse weights one input per cycle, into all EXCNUM membranes in parallel. It then applies leak, threshold, refractory period and optional winner-take-all lateral inhibition, and emits the output spike vector. Weights are held in the block and written at runtime through a simple write port.

---
 rtl/snn_pkg.sv | 36 +++
 rtl/lif_neuron.sv | 72 +++++++
 rtl/snn_layer.sv | 170 +++++++++++++++++
 tb/tb_snn_layer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking layer: FSM state encoding, default
// neuron constants and a width-generic saturating adder.
//   sat_add(a, b, w): a + b clamped to the signed range of w bits; operands
//   are passed sign-extended to SAT_W and the caller truncates back to w.
package snn_pkg;

  localparam int unsigned SAT_W          = 64;
  localparam int unsigned DEF_LEAK_SHIFT = 4;
  localparam logic signed [23:0] DEF_THRESH = 24'sd40000;
  localparam logic signed [15:0] DEF_WINIT  = 16'sd2000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FIRE  = 2'd2,
    ST_EMIT  = 2'd3
  } state_e;

  // One guard bit above SAT_W keeps the raw sum exact before clamping.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W:0] s;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (w - 1));
    if (s > hi)      return SAT_W'(hi);
    else if (s < lo) return SAT_W'(lo);
    else             return SAT_W'(s);
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, saturating integrate, threshold
// compare and refractory countdown. The layer decides who actually fires.
//   clk, rst     : clock, synchronous active-high reset
//   upd_i        : apply the timestep update this cycle
//   acc_i        : accumulated synaptic input for the timestep
//   fire_i       : layer grants a spike (only ever set when cand_c is high)
//   inhibit_i    : lateral inhibition, clears the membrane of a loser
//   cand_c       : non-refractory and v' >= THRESH (combinational)
//   vp_c         : candidate membrane v', exported only in the
//                  SNN_LAYER_WTA_EN build where the arbiter compares it
module lif_neuron
  import snn_pkg::*;
#(
  parameter int unsigned          MW         = 24,
  parameter logic signed [MW-1:0] THRESH     = DEF_THRESH,
  parameter int unsigned          LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned          REFRAC     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd_i,
  input  logic signed [MW-1:0] acc_i,
  input  logic                 fire_i,
  input  logic                 inhibit_i,
`ifdef SNN_LAYER_WTA_EN
  output logic signed [MW-1:0] vp_c,
`endif
  output logic                 cand_c
);

  logic signed [MW-1:0] v_q, v_d;
  logic [3:0]           r_q, r_d;
  logic signed [MW-1:0] leak_c;
  logic signed [MW-1:0] vp_int_c;

  // Leak never overflows: it moves v towards zero by at most |v|.
  always_comb begin
    leak_c   = v_q - (v_q >>> LEAK_SHIFT);
    vp_int_c = MW'(sat_add(SAT_W'(leak_c), SAT_W'(acc_i), MW));
    cand_c   = (r_q == 4'd0) && (vp_int_c >= THRESH);
    v_d      = v_q;
    r_d      = r_q;
    if (upd_i) begin
      if (r_q != 4'd0) begin
        r_d = r_q - 4'd1;
        v_d = leak_c;
      end else if (fire_i) begin
        v_d = '0;
        r_d = 4'(REFRAC);
      end else if (inhibit_i) begin
        v_d = '0;
      end else begin
        v_d = vp_int_c;
      end
    end
  end

`ifdef SNN_LAYER_WTA_EN
  assign vp_c = vp_int_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      r_q <= '0;
    end else begin
      v_q <= v_d;
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/snn_layer.sv
// Parametrised LIF excitatory layer. Accepts an input spike vector, sums the
// weights of active inputs into every neuron (one input per cycle), applies
// the neuron update and emits a one-cycle output spike vector.
// Build option: SNN_LAYER_WTA_EN enables winner-take-all lateral inhibition.
//   clk, rst                 : clock, synchronous active-high reset
//   en                       : global enable, low freezes all state
//   in_valid/in_ready        : input handshake, in_spikes is the vector
//   w_wr_en/pre/post/data    : runtime weight write, honoured only in IDLE
//   out_valid/out_spikes     : one-cycle result pulse, spikes held afterwards
//   busy                     : a timestep is in progress
module snn_layer
  import snn_pkg::*;
#(
  parameter int unsigned                  DW         = 16,
  parameter int unsigned                  INT_DW     = 8,
  parameter int unsigned                  INPUTNUM   = 10,
  parameter int unsigned                  EXCNUM     = 2,
  parameter logic signed [DW+INT_DW-1:0]  THRESH     = DEF_THRESH,
  parameter int unsigned                  LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int unsigned                  REFRAC     = 3,
  parameter logic signed [DW-1:0]         WINIT      = DEF_WINIT,
  localparam int unsigned PRE_W  = (INPUTNUM > 1) ? $clog2(INPUTNUM) : 1,
  localparam int unsigned POST_W = (EXCNUM > 1) ? $clog2(EXCNUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INPUTNUM-1:0]  in_spikes,
  input  logic                 w_wr_en,
  input  logic [PRE_W-1:0]     w_wr_pre,
  input  logic [POST_W-1:0]    w_wr_post,
  input  logic signed [DW-1:0] w_wr_data,
  output logic                 out_valid,
  output logic [EXCNUM-1:0]    out_spikes,
  output logic                 busy
);

  localparam int unsigned MW = DW + INT_DW;

  state_e               state_q, state_d;
  logic [PRE_W-1:0]     idx_q, idx_d;
  logic [INPUTNUM-1:0]  spk_q;
  logic signed [MW-1:0] acc_q [EXCNUM];
  logic signed [DW-1:0] w_q [INPUTNUM][EXCNUM];
  logic                 out_valid_q;
  logic [EXCNUM-1:0]    out_spikes_q;

  logic                 accept_c;
  logic                 upd_c;
  logic                 w_ok_c;
  logic [EXCNUM-1:0]    cand_c;
  logic [EXCNUM-1:0]    win_c;
  logic [EXCNUM-1:0]    inh_c;

  assign in_ready   = en && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign accept_c   = in_valid && in_ready;
  assign upd_c      = en && (state_q == ST_FIRE);
  assign w_ok_c     = w_wr_en && in_ready && (32'(w_wr_pre) < INPUTNUM)
                      && (32'(w_wr_post) < EXCNUM);
  assign out_valid  = out_valid_q;
  assign out_spikes = out_spikes_q;

  // Next-state logic; en low holds every register including the FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_ACCUM;
            idx_d   = '0;
          end
        end
        ST_ACCUM: begin
          if (32'(idx_q) == INPUTNUM - 1) state_d = ST_FIRE;
          else                            idx_d   = idx_q + PRE_W'(1);
        end
        ST_FIRE: state_d = ST_EMIT;
        ST_EMIT: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, accumulators and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      spk_q        <= '0;
      out_valid_q  <= 1'b0;
      out_spikes_q <= '0;
      for (int k = 0; k < int'(EXCNUM); k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= (state_d == ST_EMIT);
      if (accept_c) begin
        spk_q <= in_spikes;
        for (int k = 0; k < int'(EXCNUM); k++) acc_q[k] <= '0;
      end else if (en && (state_q == ST_ACCUM) && spk_q[idx_q]) begin
        for (int k = 0; k < int'(EXCNUM); k++)
          acc_q[k] <= MW'(sat_add(SAT_W'(acc_q[k]), SAT_W'(w_q[idx_q][k]), MW));
      end
      if (upd_c) out_spikes_q <= win_c;
    end
  end

  // Weight store; a write alongside an accept lands before ACCUM reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(INPUTNUM); i++)
        for (int k = 0; k < int'(EXCNUM); k++)
          w_q[i][k] <= WINIT;
    end else if (w_ok_c) begin
      w_q[w_wr_pre][w_wr_post] <= w_wr_data;
    end
  end

`ifdef SNN_LAYER_WTA_EN
  logic signed [MW-1:0] vp_c [EXCNUM];
  logic                 found_c;
  logic signed [MW-1:0] best_c;
`endif

  // Fire arbitration: strict '>' keeps the lowest index on ties.
  always_comb begin
    win_c = '0;
    inh_c = '0;
`ifdef SNN_LAYER_WTA_EN
    found_c = 1'b0;
    best_c  = '0;
    for (int k = 0; k < int'(EXCNUM); k++) begin
      if (cand_c[k] && (!found_c || (vp_c[k] > best_c))) begin
        found_c = 1'b1;
        best_c  = vp_c[k];
        win_c   = EXCNUM'(1) << k;
      end
    end
    if (found_c) inh_c = ~win_c;
`else
    win_c = cand_c;
`endif
  end

  for (genvar k = 0; k < int'(EXCNUM); k++) begin : g_neuron
    lif_neuron #(
      .MW         (MW),
      .THRESH     (THRESH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REFRAC     (REFRAC)
    ) u_neuron (
      .clk       (clk),
      .rst       (rst),
      .upd_i     (upd_c),
      .acc_i     (acc_q[k]),
      .fire_i    (win_c[k]),
      .inhibit_i (inh_c[k]),
`ifdef SNN_LAYER_WTA_EN
      .vp_c      (vp_c[k]),
`endif
      .cand_c    (cand_c[k])
    );
  end

endmodule

// File: tb/tb_snn_layer.sv
// Directed bench for snn_layer with the default 10-input, 2-neuron config.
module tb_snn_layer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_spikes;
  logic        w_wr_en;
  logic [3:0]  w_wr_pre;
  logic [0:0]  w_wr_post;
  logic signed [15:0] w_wr_data;
  logic        out_valid;
  logic [1:0]  out_spikes;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SNN_LAYER_WTA_EN
  localparam logic [1:0] E3 = 2'b01, E6 = 2'b10, E9 = 2'b01;
`else
  localparam logic [1:0] E3 = 2'b11, E6 = 2'b00, E9 = 2'b11;
`endif

  snn_layer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_spikes  (in_spikes),
    .w_wr_en    (w_wr_en),
    .w_wr_pre   (w_wr_pre),
    .w_wr_post  (w_wr_post),
    .w_wr_data  (w_wr_data),
    .out_valid  (out_valid),
    .out_spikes (out_spikes),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_w(input logic [3:0] pre, input logic post, input logic signed [15:0] data);
    w_wr_en = 1'b1; w_wr_pre = pre; w_wr_post = post; w_wr_data = data;
    @(negedge clk);
    w_wr_en = 1'b0;
  endtask

  // One timestep: accept, optional stall/busy write, then check latency and spikes.
  task automatic run_ts(input string tag, input logic [9:0] spk, input logic [1:0] exp_spk,
                        input int stall_at, input int exp_lat, input bit emit_hold,
                        input bit acc_wr, input bit busy_wr);
    int cyc;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_spikes = spk;
    in_valid  = 1'b1;
    if (acc_wr) begin
      w_wr_en = 1'b1; w_wr_pre = 4'd0; w_wr_post = 1'b0; w_wr_data = 16'sh7FFF;
    end
    @(negedge clk);
    in_valid = 1'b0;
    w_wr_en  = 1'b0;
    cyc      = 1;
    while (!out_valid && cyc < 60) begin
      if (busy_wr && cyc == 2) begin
        w_wr_en = 1'b1; w_wr_pre = 4'd0; w_wr_post = 1'b0; w_wr_data = 16'sh8000;
      end else begin
        w_wr_en = 1'b0;
      end
      if (cyc == stall_at) begin
        en = 1'b0;
        repeat (5) @(negedge clk);
        en  = 1'b1;
        cyc += 5;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    w_wr_en = 1'b0;
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_spk"}, 32'(out_spikes), 32'(exp_spk));
    if (emit_hold) begin
      en = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check({tag, "_hold"}, 32'(out_valid), 32'd1);
      end
      en = 1'b1;
    end
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_keep"}, 32'(out_spikes), 32'(exp_spk));
  endtask

  logic [1:0] seq_exp [9];
  int acc_t[$];
  int ov_t[$];
  int ready_bad;
  int pulses;

  initial begin
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_spikes = '0;
    w_wr_en = 1'b0; w_wr_pre = '0; w_wr_post = '0; w_wr_data = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_spikes", 32'(out_spikes), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    en = 1'b0;
    #1 check("ready_en_low", 32'(in_ready), 32'd0);
    en = 1'b1;

    // Integrate, fire, refractory, resume
    seq_exp = '{2'b00, 2'b00, E3, 2'b00, 2'b00, E6, 2'b00, 2'b00, E9};
    for (int t = 0; t < 9; t++)
      run_ts($sformatf("seq%0d", t + 1), 10'h3FF, seq_exp[t], -1, 12, (t == 0), 1'b0, 1'b0);

    // en stalls mid-ACCUM delay the result by exactly the stall length
    do_reset();
    run_ts("stall1", 10'h3FF, 2'b00, 3, 17, 1'b0, 1'b0, 1'b0);
    run_ts("stall2", 10'h3FF, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("stall3", 10'h3FF, E3, 7, 17, 1'b0, 1'b0, 1'b0);

    // Column 1 gets a single full-scale weight on input 0
    do_reset();
    write_w(4'd0, 1'b1, 16'sh7FFF);
    for (int i = 1; i < 10; i++) write_w(4'(i), 1'b1, 16'sd0);
    run_ts("wr1", 10'h001, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("wr2", 10'h001, 2'b10, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("wr3", 10'h001, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);

    // Write coinciding with accept is used by that timestep: 32767+9*2000
    do_reset();
    run_ts("acc_wr", 10'h3FF, 2'b01, -1, 12, 1'b0, 1'b1, 1'b0);

    // Busy writes are dropped
    do_reset();
    run_ts("bw1", 10'h3FF, 2'b00, -1, 12, 1'b0, 1'b0, 1'b1);
    run_ts("bw2", 10'h3FF, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("bw3", 10'h3FF, E3, -1, 12, 1'b0, 1'b0, 1'b0);

    // Handshake: in_valid held high through several timesteps
    do_reset();
    ready_bad = 0;
    in_spikes = 10'h3FF;
    in_valid  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (in_valid && in_ready) acc_t.push_back(n);
      if (busy && in_ready) ready_bad++;
      if (out_valid) ov_t.push_back(n);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("hs_accepts", 32'(acc_t.size()), 32'd4);
    if (acc_t.size() >= 4) begin
      check("hs_gap1", 32'(acc_t[1] - acc_t[0]), 32'd13);
      check("hs_gap3", 32'(acc_t[3] - acc_t[2]), 32'd13);
    end
    check("hs_ready_busy", 32'(ready_bad), 32'd0);
    check("hs_ov_count", 32'(ov_t.size()), 32'd3);
    if (ov_t.size() >= 1) check("hs_ov_first", 32'(ov_t[0]), 32'd12);

    // Reset mid-ACCUM aborts and restores default weights
    do_reset();
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < 2; k++) write_w(4'(i), 1'(k), 16'sd0);
    in_spikes = 10'h3FF;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (20) begin
      if (out_valid) pulses++;
      @(negedge clk);
    end
    check("rstmid_no_pulse", 32'(pulses), 32'd0);
    run_ts("rw1", 10'h3FF, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("rw2", 10'h3FF, 2'b00, -1, 12, 1'b0, 1'b0, 1'b0);
    run_ts("rw3", 10'h3FF, E3, -1, 12, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
